// File: rtl/jpeg_stuff_pack_if.sv
// Byte-stream bundle shared by the stuffer input and packer output.
// Ports: data (left-justified), nbytes, bypass, tlast, valid; hold back.
interface jpeg_stuff_pack_if #(
    parameter int NB = 4
);
    logic [8*NB-1:0]          data;
    logic [$clog2(NB+1)-1:0]  nbytes;
    logic                     bypass;
    logic                     tlast;
    logic                     valid;
    logic                     hold;

    modport master (
        output data, nbytes, bypass, tlast, valid,
        input  hold
    );

    modport slave (
        input  data, nbytes, bypass, tlast, valid,
        output hold
    );
endinterface

// File: rtl/jpeg_stuff_pack.sv
// JPEG entropy byte stuffer (0xFF -> 0xFF 0x00) and output word packer.
// Ports: clk, reset (sync, active-high), in_if (slave), out_if (master),
// stuff_count (saturating inserted-zero count), err (sticky nbytes overflow).
module jpeg_stuff_pack #(
    parameter int IN_BYTES  = 4,
    parameter int OUT_BYTES = 8,
    parameter int CNT_W     = 32
) (
    input  logic              clk,
    input  logic              reset,
    jpeg_stuff_pack_if.slave  in_if,
    jpeg_stuff_pack_if.master out_if,
    output logic [CNT_W-1:0]  stuff_count,
    output logic              err
);
    localparam int S1B = 2*IN_BYTES;
    localparam int ACC = OUT_BYTES - 1 + S1B;
    localparam int S1W = $clog2(S1B+1);
    localparam int SW  = $clog2(IN_BYTES+1);
    localparam int OW  = $clog2(OUT_BYTES+1);
    localparam int AW  = $clog2(ACC+1);

    typedef enum logic {FILL, DRAIN} state_t;

    state_t           state;
    logic [8*S1B-1:0] s1_d;
    logic [S1W-1:0]   s1_n;
    logic             s1_last;
    logic             s1_full;
    logic [8*ACC-1:0] acc;
    logic [AW-1:0]    acc_n;

    logic [8*S1B-1:0] st_d;
    logic [S1W-1:0]   st_n;
    logic [SW-1:0]    st_ins;
    logic             st_ovf;

    // Stuffing: walk valid lanes, emitting each byte plus a zero after FF.
    // Bytes past the valid count stay zero, so the accumulator keeps its
    // unused tail clear and can be merged with a plain OR.
    always_comb begin
        int         nv;
        int         p;
        int         ins;
        logic [7:0] b;
        nv     = int'(in_if.nbytes);
        st_ovf = nv > IN_BYTES;
        if (st_ovf)
            nv = IN_BYTES;
        p    = 0;
        ins  = 0;
        b    = '0;
        st_d = '0;
        for (int i = 0; i < IN_BYTES; i++) begin
            if (i < nv) begin
                b    = in_if.data[8*(IN_BYTES-1-i) +: 8];
                st_d = st_d | ({b, {(8*S1B-8){1'b0}}} >> (8*p));
                p    = p + 1;
                if (b == 8'hFF && !in_if.bypass) begin
                    p   = p + 1;
                    ins = ins + 1;
                end
            end
        end
        st_n   = S1W'(p);
        st_ins = SW'(ins);
    end

    logic           full;
    logic           take;
    logic           xfer;
    logic           accept;
    logic [OW-1:0]  o_n;
    logic [AW-1:0]  take_n;
    logic [AW-1:0]  base;
    logic [8*ACC-1:0] acc_nx;

    always_comb begin
        full           = acc_n >= AW'(OUT_BYTES);
        out_if.valid   = full || state == DRAIN;
        if (full)
            o_n = OW'(OUT_BYTES);
        else if (state == DRAIN)
            o_n = OW'(acc_n);
        else
            o_n = '0;
        out_if.tlast   = state == DRAIN && acc_n <= AW'(OUT_BYTES);
        out_if.nbytes  = o_n;
        out_if.bypass  = 1'b0;
        out_if.data    = acc[8*ACC-1 -: 8*OUT_BYTES]
                       & ~({(8*OUT_BYTES){1'b1}} >> (8*o_n));
        take   = out_if.valid && !out_if.hold;
        take_n = take ? AW'(o_n) : '0;
        base   = acc_n - take_n;
        // Room check uses the level after this cycle's take so that a
        // full word can leave while the next beat lands behind it.
        xfer   = s1_full && state == FILL && base < AW'(OUT_BYTES);
        in_if.hold = s1_full && !xfer;
        accept = in_if.valid && !in_if.hold;
        acc_nx = acc << (8*take_n);
        if (xfer)
            acc_nx = acc_nx
                   | ({s1_d, {(8*(ACC-S1B)){1'b0}}} >> (8*base));
    end

    logic [CNT_W:0] cnt_sum;
    assign cnt_sum = {1'b0, stuff_count} + (CNT_W+1)'(st_ins);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= FILL;
            s1_d        <= '0;
            s1_n        <= '0;
            s1_last     <= 1'b0;
            s1_full     <= 1'b0;
            acc         <= '0;
            acc_n       <= '0;
            stuff_count <= '0;
            err         <= 1'b0;
        end else begin
            if (!in_if.hold) begin
                s1_full <= accept;
                if (accept) begin
                    s1_d    <= st_d;
                    s1_n    <= st_n;
                    s1_last <= in_if.tlast;
                end
            end
            if (accept) begin
                stuff_count <= cnt_sum[CNT_W] ? '1
                                              : cnt_sum[CNT_W-1:0];
                if (st_ovf)
                    err <= 1'b1;
            end
            if (take || xfer) begin
                acc   <= acc_nx;
                acc_n <= base + (xfer ? AW'(s1_n) : '0);
            end
            if (xfer && s1_last)
                state <= DRAIN;
            else if (take && out_if.tlast)
                state <= FILL;
        end
    end
endmodule

// File: doc/jpeg_stuff_pack.md
# jpeg_stuff_pack

Parametrised JPEG entropy-segment byte stuffer and output packer for the `jenc` back end. It inserts 0x00 after every 0xFF data byte, with a per-beat bypass for marker insertion. Stuffed bytes are re-aligned into fixed-width, left-justified output words, and a partial final word is flushed on `tlast`. It sits between the Huffman bit packer and the JPEG stream/AXIS output, and is the generalised successor of the fixed 4-in/8-out stuffer.

## Interface
- `IN_BYTES`, 4 — input word width in bytes; must be ≥1.
- `OUT_BYTES`, 8 — output word width in bytes; must be ≥ 2*`IN_BYTES`.
- `CNT_W`, 32 — width of the stuffed-byte statistics counter.
- `clk` in 1 — single clock, all logic on its rising edge.
- `reset` in 1 — synchronous, active-high.
- `in_data` in 8*`IN_BYTES` — input bytes, first byte in the MSB lane, left-justified.
- `in_nbytes` in $clog2(`IN_BYTES`+1) — count of valid bytes from the MSB lane.
- `in_bypass` in 1 — 1 passes this beat unstuffed (markers such as FFD9).
- `in_tlast` in 1 — last beat of the segment.
- `in_valid` in 1 — beat present.
- `in_hold` out 1 — back-pressure; the beat is accepted when `in_valid & ~in_hold`.
- `out_data` out 8*`OUT_BYTES` — output bytes, left-justified, unused lanes 0.
- `out_nbytes` out $clog2(`OUT_BYTES`+1) — valid byte count.
- `out_tlast` out 1 — final word of the segment.
- `out_valid` out 1 — word present.
- `out_hold` in 1 — downstream stall; the word is taken when `out_valid & ~out_hold`.
- `stuff_count` out `CNT_W` — saturating count of inserted 0x00 bytes since reset.
- `err` out 1 — sticky flag, set when an accepted beat has `in_nbytes` > `IN_BYTES`.

## Operation
- **Stage 1 (stuff register).** For each valid lane with byte 0xFF and `in_bypass`=0, append 0x00 right after it and shift the following bytes down one lane.
  - Result: up to 2*`IN_BYTES` bytes, left-justified.
  - Count: `in_nbytes` + number of 0xFF lanes.
  - Invalid lanes are never examined.
  - An `in_nbytes` overflow is clamped to `IN_BYTES` and sets `err`.
- **Stage 2 (accumulator).** Byte buffer of ACC = `OUT_BYTES`-1+2*`IN_BYTES` bytes, with a count `acc_n`, and a `flush` flag.
  - `out_data` is the top `OUT_BYTES` bytes of the accumulator with lanes ≥ `out_nbytes` forced to 0.
- **States.**
  - FILL: `flush`=0.
  - DRAIN: `flush`=1, set when a tlast beat enters the accumulator.
- **Output presentation.**
  - `out_valid`=1 when `acc_n` ≥ `OUT_BYTES`, with `out_nbytes`=`OUT_BYTES`.
  - Or, in DRAIN, when `acc_n` < `OUT_BYTES`: `out_nbytes`=`acc_n` (may be 0), with `out_tlast`=1.
  - In DRAIN, a full word that leaves `acc_n`=0 also carries `out_tlast`=1 and ends DRAIN. No extra empty word follows.
- **Output handshake.** On a taken word, shift the buffer left by `out_nbytes` and subtract `out_nbytes` from `acc_n`. If the taken word had `out_tlast`=1, return to FILL.
- **Stage 1 → 2 transfer.** Allowed only in FILL, and only when `acc_n` minus the bytes taken this cycle is < `OUT_BYTES`. Data is appended at offset (`acc_n` − taken).
- **In DRAIN,** stage 1 holds.
- **Hold chain.**
  - Stage 1 advances when empty or transferring.
  - `in_hold` = stage 1 full and not transferring (combinational).
- **`stuff_count`** adds the inserts of each accepted beat and saturates at all-ones.

## Timing
- **Reset** (synchronous): `out_valid`=0, `out_data`=0, `out_nbytes`=0, `out_tlast`=0, `stuff_count`=0, `err`=0, `acc_n`=0, state FILL, stage 1 empty. `in_hold`=0 in the cycle after reset.
- **Reset mid-segment** discards all buffered bytes, with no flush.
- **Latency:** a beat accepted at edge N is in stage 1 after N and in the accumulator after N+1. A word completed by it has `out_valid` high after edge N+1.
- **Throughput:** one input beat per cycle sustained in FILL with `out_hold`=0, including the worst case of all 0xFF.
- **Simultaneous output take and transfer** in the same cycle is required.
- **Segment gap:** the DRAIN → FILL transition costs at most one input-idle cycle per segment.
- **Holding:** `out_*` holds stable while `out_valid & out_hold`.
- **`in_nbytes`=0 beats** are legal; they carry only `tlast`.

## Test plan
- **All-FF stream.** `IN_BYTES`=4, `OUT_BYTES`=8, `in_data`=FFFFFFFF, `in_nbytes`=4, three beats, last one tlast.
  - Expect three words FF00FF00FF00FF00.
  - The last has `out_tlast`=1 and `out_nbytes`=8.
  - `stuff_count`=12; no idle input cycles.
- **Bypass marker.** Beat 12FF3400 with `in_nbytes`=3, then tlast beat FFD90000 with `in_bypass`=1, `in_nbytes`=2.
  - Expect one word 12FF0034FFD90000 with `out_nbytes`=6 and `out_tlast`=1.
  - `stuff_count`=1.
- **Zero-byte tlast.** Empty accumulator, beat with `in_nbytes`=0 and tlast.
  - Expect one word with `out_nbytes`=0, `out_tlast`=1, `out_data`=0.
- **Back-pressure.** Random `out_hold` at 50% over a 1000-beat random stream with ~20% 0xFF bytes.
  - Reassembled output must equal the software stuffing model.
  - Output stays stable while held; no loss or duplication.
- **Overflow and reset.** A beat with `in_nbytes`=7 sets `err` and is treated as 4 bytes.
  - `reset` asserted mid-DRAIN clears all outputs to 0 next cycle, and the next segment starts clean.
- **Parameter sweep.** `IN_BYTES`∈{1,2,4}, `OUT_BYTES`∈{2*`IN_BYTES`, 16}, rerunning the random scoreboard test.
